// File: rtl/sbm_pkg.sv
// Shared types and default sizes for the schoolbook multiplier front end.
// Also used by the top-level integration for RUN_CYCLES.
package sbm_pkg;

  localparam int SBM_SIZEA      = 1024;
  localparam int SBM_SIZEB      = 1024;
  localparam int SBM_WORD       = 64;
  localparam int SBM_RUN_CYCLES = 1600;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    RUN    = 2'd2,
    DONE   = 2'd3
  } sbm_state_t;

  // Counter width that never collapses to zero bits.
  function automatic int sbm_cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sbm_word_deser.sv
// Writes one stream word into a full-width operand register.
// The word slot is selected by the loader's shared word counter.
module sbm_word_deser #(
  parameter int SIZE = 1024,
  parameter int WORD = 64,
  parameter int IW   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            enable,
  input  logic [WORD-1:0] in_data,
  input  logic [IW-1:0]   idx,
  output logic [SIZE-1:0] q
);

  localparam int N = SIZE / WORD;

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= '0;
    end else if (enable) begin
      for (int k = 0; k < N; k++) begin
        if (idx == IW'(k)) begin
          q[k*WORD +: WORD] <= in_data;
        end
      end
    end
  end

endmodule

// File: rtl/sbm_operand_loader.sv
// Streams operands A then B into wide buses and sequences the
// multiplier through a fixed run window, pulsing mul_done at the end.
module sbm_operand_loader
  import sbm_pkg::*;
#(
  parameter int SIZEA      = SBM_SIZEA,
  parameter int SIZEB      = SBM_SIZEB,
  parameter int WORD       = SBM_WORD,
  parameter int RUN_CYCLES = SBM_RUN_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WORD-1:0]  in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [SIZEA-1:0] a,
  output logic [SIZEB-1:0] b,
  output logic             mul_rst,
  output logic             mul_done,
  output logic             busy
);

  localparam int NA  = SIZEA / WORD;
  localparam int NB  = SIZEB / WORD;
  localparam int WCW = sbm_cw((NA > NB) ? NA : NB);
  localparam int RCW = sbm_cw(RUN_CYCLES);

  sbm_state_t     state;
  logic [WCW-1:0] wcnt;
  logic [RCW-1:0] rcnt;
  logic           acc_a;
  logic           acc_b;

  assign in_ready = (state == LOAD_A) || (state == LOAD_B);
  assign acc_a    = in_valid && (state == LOAD_A);
  assign acc_b    = in_valid && (state == LOAD_B);

  sbm_word_deser #(
    .SIZE(SIZEA), .WORD(WORD), .IW(WCW)
  ) u_deser_a (
    .clk    (clk),
    .rst    (rst),
    .enable (acc_a),
    .in_data(in_data),
    .idx    (wcnt),
    .q      (a)
  );

  sbm_word_deser #(
    .SIZE(SIZEB), .WORD(WORD), .IW(WCW)
  ) u_deser_b (
    .clk    (clk),
    .rst    (rst),
    .enable (acc_b),
    .in_data(in_data),
    .idx    (wcnt),
    .q      (b)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= LOAD_A;
      wcnt     <= '0;
      rcnt     <= '0;
      mul_rst  <= 1'b1;
      mul_done <= 1'b0;
      busy     <= 1'b0;
    end else begin
      unique case (state)
        LOAD_A: begin
          if (in_valid) begin
            if (wcnt == WCW'(NA - 1)) begin
              state <= LOAD_B;
              wcnt  <= '0;
            end else begin
              wcnt <= wcnt + 1'b1;
            end
          end
        end
        LOAD_B: begin
          if (in_valid) begin
            if (wcnt == WCW'(NB - 1)) begin
              state   <= RUN;
              wcnt    <= '0;
              rcnt    <= '0;
              mul_rst <= 1'b0;
              busy    <= 1'b1;
            end else begin
              wcnt <= wcnt + 1'b1;
            end
          end
        end
        RUN: begin
          if (rcnt == RCW'(RUN_CYCLES - 1)) begin
            state    <= DONE;
            mul_done <= 1'b1;
          end else begin
            rcnt <= rcnt + 1'b1;
          end
        end
        DONE: begin
          state    <= LOAD_A;
          wcnt     <= '0;
          mul_done <= 1'b0;
          mul_rst  <= 1'b1;
          busy     <= 1'b0;
        end
        default: state <= LOAD_A;
      endcase
    end
  end

endmodule

// File: tb/tb_sbm_operand_loader.sv
// Randomized scenario bench for sbm_operand_loader against a
// word-count / run-countdown reference model.
module tb_sbm_operand_loader;

  localparam int SA = 1024;
  localparam int SB = 1024;
  localparam int W  = 64;
  localparam int RC = 1600;
  localparam int NA = SA / W;
  localparam int NB = SB / W;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [W-1:0]  in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [SA-1:0] a;
  logic [SB-1:0] b;
  logic          mul_rst;
  logic          mul_done;
  logic          busy;

  int checks = 0;
  int errors = 0;

  // Reference model: words accepted so far in this job, and position
  // in the run window (0 = loading, 1..RC = running, RC+1 = done pulse).
  int            m_words = 0;
  int            m_run = 0;
  logic [SA-1:0] ref_a = '0;
  logic [SB-1:0] ref_b = '0;

  sbm_operand_loader #(
    .SIZEA(SA), .SIZEB(SB), .WORD(W), .RUN_CYCLES(RC)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .in_data (in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .a       (a),
    .b       (b),
    .mul_rst (mul_rst),
    .mul_done(mul_done),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  task automatic step(input logic v, input logic [W-1:0] d,
                      input logic r);
    in_valid = v;
    in_data  = d;
    rst      = r;
    if (r) begin
      m_words = 0;
      m_run   = 0;
      ref_a   = '0;
      ref_b   = '0;
    end else if (m_run == 0) begin
      if (v) begin
        if (m_words < NA) ref_a[W*m_words +: W] = d;
        else ref_b[W*(m_words-NA) +: W] = d;
        m_words++;
        if (m_words == NA + NB) begin
          m_words = 0;
          m_run   = 1;
        end
      end
    end else if (m_run == RC + 1) begin
      m_run = 0;
    end else begin
      m_run++;
    end
    @(posedge clk);
    #1;
  endtask

  // Advance until mul_done is seen or the bound expires, tallying
  // cycles whose control outputs disagree with the model.
  task automatic run_wait(input int bound, input logic v,
                          input logic [W-1:0] d, output int n,
                          output int bad, output bit seen);
    n = 0; bad = 0; seen = 0;
    while (n < bound && !seen) begin
      step(v, d, 1'b0);
      n++;
      if (mul_rst !== (m_run == 0) || busy !== (m_run != 0) ||
          mul_done !== (m_run == RC + 1) ||
          in_ready !== (m_run == 0)) bad++;
      if (mul_done === 1'b1) seen = 1;
    end
  endtask

  task automatic load_random();
    for (int i = 0; i < NA + NB; i++)
      step(1'b1, {$urandom, $urandom}, 1'b0);
  endtask

  task automatic test_reset();
    repeat (3) step(1'b0, '0, 1'b1);
    checks++;
    if (a !== '0 || b !== '0) begin
      errors++;
      $display("FAIL reset_ab: a_lo=%h b_lo=%h required 0", a[63:0], b[63:0]);
    end
    checks++;
    if ({mul_rst, mul_done, busy} !== 3'b100) begin
      errors++;
      $display("FAIL reset_ctl: rst/done/busy=%b required 100",
               {mul_rst, mul_done, busy});
    end
    step(1'b0, '0, 1'b0);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready: in_ready=%b required 1", in_ready);
    end
  endtask

  task automatic test_basic();
    int n, bad;
    bit seen;
    for (int i = 0; i < NA; i++) step(1'b1, W'(i + 1), 1'b0);
    for (int i = 0; i < NB; i++) step(1'b1, '1, 1'b0);
    checks++;
    if (mul_rst !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL basic_start: mul_rst=%b busy=%b required 0 1",
               mul_rst, busy);
    end
    run_wait(RC + 10, 1'b0, '0, n, bad, seen);
    checks++;
    if (n !== RC || !seen) begin
      errors++;
      $display("FAIL basic_latency: cycles=%0d required %0d", n, RC);
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL basic_ctl: bad cycles=%0d required 0", bad);
    end
    checks++;
    if (a[63:0] !== 64'd1 || a[1023:960] !== 64'h10) begin
      errors++;
      $display("FAIL basic_a_ends: lo=%h hi=%h required 1 10",
               a[63:0], a[1023:960]);
    end
    checks++;
    if (a !== ref_a || b !== ref_b || ~b !== '0) begin
      errors++;
      $display("FAIL basic_ab: a_lo=%h b_lo=%h required %h %h",
               a[63:0], b[63:0], ref_a[63:0], ref_b[63:0]);
    end
    step(1'b0, '0, 1'b0);
    checks++;
    if ({mul_rst, in_ready, mul_done, busy} !== 4'b1100) begin
      errors++;
      $display("FAIL basic_after: rst/rdy/done/busy=%b required 1100",
               {mul_rst, in_ready, mul_done, busy});
    end
  endtask

  task automatic test_stalls();
    int n, bad, hold_bad;
    bit seen;
    logic [SA-1:0] snap_a;
    hold_bad = 0;
    for (int i = 0; i < NA + NB; i++) begin
      step(1'b1, {$urandom, $urandom}, 1'b0);
      if (i != NA + NB - 1) begin
        snap_a = a;
        step(1'b0, {$urandom, $urandom}, 1'b0);
        if (a !== snap_a || mul_rst !== 1'b1 || in_ready !== 1'b1)
          hold_bad++;
      end
    end
    checks++;
    if (hold_bad !== 0) begin
      errors++;
      $display("FAIL stall_hold: bad stall cycles=%0d required 0", hold_bad);
    end
    checks++;
    if (a !== ref_a || b !== ref_b) begin
      errors++;
      $display("FAIL stall_ab: a_lo=%h b_hi=%h required %h %h",
               a[63:0], b[1023:960], ref_a[63:0], ref_b[1023:960]);
    end
    run_wait(RC + 10, 1'b0, '0, n, bad, seen);
    checks++;
    if (n !== RC || bad !== 0) begin
      errors++;
      $display("FAIL stall_run: cycles=%0d bad=%0d required %0d 0",
               n, bad, RC);
    end
    step(1'b0, '0, 1'b0);
  endtask

  task automatic test_words_during_run();
    int n, bad;
    bit seen;
    logic [W-1:0] dead;
    dead = 64'hDEAD;
    load_random();
    run_wait(RC + 10, 1'b1, dead, n, bad, seen);
    checks++;
    if (!seen || bad !== 0) begin
      errors++;
      $display("FAIL run_ignore: seen=%0d bad=%0d required 1 0", seen, bad);
    end
    step(1'b1, dead, 1'b0);
    checks++;
    if (a !== ref_a || b !== ref_b || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL run_stable: a_lo=%h rdy=%b required %h 1",
               a[63:0], in_ready, ref_a[63:0]);
    end
    step(1'b1, dead, 1'b0);
    checks++;
    if (a[63:0] !== dead || a !== ref_a) begin
      errors++;
      $display("FAIL run_first_word: a_lo=%h required %h", a[63:0], dead);
    end
  endtask

  task automatic test_reset_mid_run();
    int n, bad;
    bit seen;
    step(1'b0, '0, 1'b1);
    checks++;
    if (a !== '0 || b !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_midload: a_lo=%h rdy=%b required 0 1",
               a[63:0], in_ready);
    end
    load_random();
    run_wait(500, 1'b0, '0, n, bad, seen);
    step(1'b0, '0, 1'b1);
    checks++;
    if (mul_rst !== 1'b1 || busy !== 1'b0 || a !== '0 || b !== '0) begin
      errors++;
      $display("FAIL rst_midrun: mul_rst=%b busy=%b a_lo=%h required 1 0 0",
               mul_rst, busy, a[63:0]);
    end
    run_wait(RC + 10, 1'b0, '0, n, bad, seen);
    checks++;
    if (seen || bad !== 0) begin
      errors++;
      $display("FAIL rst_nodone: seen=%0d bad=%0d required 0 0", seen, bad);
    end
    load_random();
    run_wait(RC + 10, 1'b0, '0, n, bad, seen);
    checks++;
    if (n !== RC || !seen || a !== ref_a || b !== ref_b) begin
      errors++;
      $display("FAIL rst_reload: cycles=%0d seen=%0d required %0d 1",
               n, seen, RC);
    end
  endtask

  task automatic test_back_to_back();
    int n, bad, highs, dones;
    bit seen;
    dones = 0;
    step(1'b0, '0, 1'b0);
    for (int i = 0; i < NA + NB; i++)
      step(1'b1, (i == 0) ? 64'd3 : (i == NA) ? 64'd5 : 64'd0, 1'b0);
    run_wait(RC + 10, 1'b0, '0, n, bad, seen);
    if (seen) dones++;
    checks++;
    if (a[63:0] * b[63:0] !== 64'd15 || a !== ref_a || b !== ref_b) begin
      errors++;
      $display("FAIL b2b_first: a_lo=%h b_lo=%h required 3 5",
               a[63:0], b[63:0]);
    end
    highs = 0;
    step(1'b0, '0, 1'b0);
    if (mul_rst === 1'b1) highs++;
    for (int i = 0; i < NA + NB; i++) begin
      step(1'b1, (i < NA) ? 64'd0 : {$urandom, $urandom}, 1'b0);
      if (mul_rst === 1'b1) highs++;
    end
    checks++;
    if (highs !== NA + NB) begin
      errors++;
      $display("FAIL b2b_gap: mul_rst high cycles=%0d required %0d",
               highs, NA + NB);
    end
    run_wait(RC + 10, 1'b0, '0, n, bad, seen);
    if (seen) dones++;
    checks++;
    if (dones !== 2 || bad !== 0) begin
      errors++;
      $display("FAIL b2b_dones: pulses=%0d bad=%0d required 2 0", dones, bad);
    end
    checks++;
    if (a !== '0 || b !== ref_b) begin
      errors++;
      $display("FAIL b2b_second: a_lo=%h b_lo=%h required 0 %h",
               a[63:0], b[63:0], ref_b[63:0]);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stalls();
    test_words_during_run();
    test_reset_mid_run();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sbm_operand_loader.md
# sbm_operand_loader

Operand front end for the digit-serial schoolbook multiplier (`sbm_digitized`, 1024×1024, 8-bit digits). It accepts both operands as a stream of narrow words with a valid/ready handshake and assembles them into the full-width `a` and `b` buses. It holds the multiplier in reset while loading, then releases it for a fixed run window. At the end of the window it pulses `mul_done`, so the downstream consumer can capture the 2048-bit product `c`.

## Interface
- SIZEA, 1024, width of operand A in bits; must be a multiple of WORD
- SIZEB, 1024, width of operand B in bits; must be a multiple of WORD
- WORD, 64, input stream word width
- RUN_CYCLES, 1600, cycles the multiplier is held out of reset; covers 128 digits × 12 cycles plus margin
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  reset, synchronous, active-high
- in_data  in  WORD  operand word
- in_valid  in  1  in_data is valid
- in_ready  out  1  loader accepts a word this cycle
- a  out  SIZEA  assembled operand A; drives multiplier `a`
- b  out  SIZEB  assembled operand B; drives multiplier `b`
- mul_rst  out  1  reset to the multiplier; high except during RUN and DONE
- mul_done  out  1  one-cycle pulse; the multiplier product is final and stable
- busy  out  1  high in RUN and DONE

## Operation
- **Reset values:**
  - a = 0, b = 0
  - mul_rst = 1, mul_done = 0, busy = 0
  - state = LOAD_A, word counter = 0, run counter = 0
  - in_ready is combinational from state, so it is 1 in the first cycle after reset deasserts.
- **States:**
  - LOAD_A: in_ready = 1. Each accepted word (in_valid && in_ready) is written to a[WORD*k +: WORD], with k = word counter, starting at 0. The order is little-endian: word 0 lands at a[WORD-1:0]. After word SIZEA/WORD−1 is accepted, go to LOAD_B and clear the word counter.
  - LOAD_B: same as LOAD_A, but into b. After the last word is accepted, go to RUN and clear the run counter.
  - RUN: in_ready = 0, mul_rst = 0, busy = 1. The run counter increments each cycle. When it reaches RUN_CYCLES−1, go to DONE.
  - DONE: mul_rst = 0, mul_done = 1, busy = 1, for exactly one cycle. Then go to LOAD_A with the word counter at 0.
- `a` and `b` change only on accepted words in their own LOAD state. They are stable throughout RUN and DONE.
- When a new load begins, words overwrite `a` and `b` in place; there is no clearing between jobs.
- Counter widths:
  - word counter: $clog2(max(SIZEA, SIZEB)/WORD)
  - run counter: $clog2(RUN_CYCLES)
- **Boundary conditions:**
  - in_valid low mid-load: stall; counters and registers hold.
  - in_valid high during RUN or DONE: ignored; the word is not consumed.
  - rst mid-load or mid-run: all registers return to their reset values; any partial operand is discarded.
  - SIZEA/WORD = 1: LOAD_A lasts exactly one accepted word.

## Timing
- A word is accepted on the rising edge where in_valid && in_ready; it is visible on `a`/`b` the next cycle.
- If the final B word is accepted at edge T:
  - state = RUN and mul_rst = 0 from cycle T+1; the multiplier's first active cycle is T+1.
  - mul_done = 1 during cycle T+1+RUN_CYCLES, and mul_rst is still 0 in that cycle.
  - mul_rst = 1 and in_ready = 1 from cycle T+2+RUN_CYCLES.
- Minimum job length: (SIZEA+SIZEB)/WORD + RUN_CYCLES + 1 cycles. With defaults this is 32 + 1600 + 1 = 1633.
- There is no combinational path from in_valid to in_ready.

## Structure
- Shared package `sbm_pkg` holds:
  - state encoding constants: LOAD_A = 0, LOAD_B = 1, RUN = 2, DONE = 3
  - default widths (SIZEA, SIZEB, WORD)
  - RUN_CYCLES default, shared with the top-level integration
- Sub-module `sbm_word_deser`, instantiated twice (A and B):
  - ports: clk, rst, enable, in_data, full-width register output
  - the word index comes from the loader's shared word counter
- The FSM and run counter stay in the top module.

## Test plan
- **Basic job:** reset, then 16 words 0x0000_0000_0000_0001..0x10 to A and 16 words of all-ones to B → a[63:0] = 1 and a[1023:960] = 0x10; b = all-ones; mul_rst falls the cycle after the last B word; mul_done pulses exactly 1600 cycles later; the multiplier's c matches the reference model.
- **Stalls:** in_valid toggled 1-0-1 every cycle → counters advance only on accepted words; the final a/b match the gap-free case; job length grows by exactly the number of stall cycles.
- **Words during RUN:** in_valid held high through RUN with data 0xDEAD → in_ready = 0; a/b unchanged; the 0xDEAD word is the first one accepted after DONE, into a[63:0].
- **Reset mid-run:** rst asserted for 1 cycle at RUN cycle 500 → mul_rst = 1, busy = 0, a = b = 0; no mul_done; a fresh 32-word load completes normally.
- **Back-to-back jobs:** operands 3×5, then 0×anything → mul_done pulses twice; products 15 and 0; mul_rst is high for exactly the 32 load cycles between the two runs.
